bpm_link_tx: RTL and testbench
==============================

BPM_LINK_TX -- requirements
Module: bpm_link_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  FIFO_DEPTH, 16, pass-through FIFO depth in words; power of two, minimum 8.
  HEADER_MAGIC, 16'hA5BC, upper 16 bits of every locally generated header word.
REQ-002 Ports, one per line: name, direction, width, meaning.
  auroraUserClk  in  1  sole clock.
  auroraReset  in  1  synchronous, active-high reset.
  auroraFAstrobe  in  1  single-cycle start-of-session marker.
  enable  in  1  permits local packet generation; sampled on auroraFAstrobe.
  localIndex  in  9  FOFB index of this BPM; sampled on auroraFAstrobe.
  localX, localY, localS  in  32 each  position and sum; sampled on auroraFAstrobe.
  RX_tdata / RX_tvalid / RX_tlast  in  32/1/1  upstream link; no back-pressure.
  TX_tdata / TX_tvalid / TX_tlast  out  32/1/1  downstream link.
  TX_tready  in  1  downstream ready.
  sentCount  out  6  local plus forwarded packets sent in the previous session.
  droppedCount  out  6  upstream packets dropped in the previous session.
  overrun  out  1  sticky; set on any drop or on a strobe while a local packet is still pending.
  overrunClear  in  1  clears overrun.

Function
REQ-003 Local packet SHALL be 4 words:
  header {HEADER_MAGIC, 7'b0, localIndex}, then X, then Y, then S.
  TX_tlast SHALL be asserted on S only.
REQ-004 On auroraFAstrobe with enable=1, localIndex/X/Y/S SHALL be latched and a local-pending flag set.
  With enable=0, nothing SHALL be latched and no flag set.
REQ-005 FSM states: IDLE, LOCAL_H, LOCAL_X, LOCAL_Y, LOCAL_S, PASS.
  Each word SHALL advance only on a TX_tvalid&&TX_tready cycle.
REQ-006 From IDLE, local-pending SHALL have priority over FIFO data.
  IDLE->LOCAL_H when pending; otherwise IDLE->PASS when the FIFO is non-empty.
REQ-007 LOCAL_S handshake SHALL clear local-pending and return to IDLE.
  A PASS word handshake carrying tlast SHALL return to IDLE.
REQ-008 Arbitration SHALL occur only at packet boundaries; a packet in progress is never interleaved.
REQ-009 FIFO handling:
  - RX words SHALL be written to the FIFO together with their tlast bit.
  - The accept/drop decision SHALL be made on the first word of each upstream packet: accept if free space >=4, else drop that word and all words through RX_tlast.
  - Each drop SHALL increment the drop counter and set overrun.
REQ-010 Output stability: TX_tvalid SHALL NOT deassert, and TX_tdata/TX_tlast SHALL NOT change, while TX_tvalid=1 and TX_tready=0.
REQ-011 FIFO-to-TX latency SHALL be 1 cycle: a word written into an empty FIFO in IDLE appears on TX on the next cycle.
REQ-012 Session boundary (auroraFAstrobe):
  - sentCount and droppedCount SHALL be loaded from the session counters, which then clear.
  - Events on the strobe cycle itself SHALL count toward the new session.
  - Counters SHALL saturate at 63.
REQ-013 A strobe arriving while local-pending is still set SHALL set overrun and overwrite the latched values.
  The packet in flight SHALL complete unchanged.
REQ-014 Simultaneous FIFO write and read SHALL leave occupancy unchanged.
  Full and empty SHALL be derived from a count of width log2(FIFO_DEPTH)+1.
REQ-015 overrunClear and a new overrun event in the same cycle: overrun SHALL be 1.

Reset
REQ-016 On auroraReset, all outputs SHALL become 0, the FSM SHALL be IDLE, the FIFO empty, local-pending 0, and all counters 0.
REQ-017 Reset mid-packet SHALL abort the packet with no further TX words.
  RX words arriving in the reset cycle SHALL be discarded.
  After reset, RX data SHALL be accepted only from the next word with the previous RX word's tlast=1.

Structure
REQ-018 HEADER_MAGIC, packet length 4, index width 9, and the state encodings SHALL live in the shared FOFB link package, alongside the constants used by the link reader.
REQ-019 The FIFO SHALL be one sub-module, link_tx_fifo: synchronous, first-word-fall-through, 33 bits wide.

Verification
REQ-020 Enabled local packet: strobe with enable=1, localIndex=9'h12A, X=1, Y=2, S=3, TX_tready=1.
  -> TX words A5BC012A, 1, 2, 3 on consecutive cycles; tlast on the fourth word only.
REQ-021 Back-pressure: TX_tready toggling 1,0,0,1,...
  -> exactly 4 words sent; data held stable while stalled; no word lost or duplicated.
REQ-022 Pass-through during a local packet: upstream 4-word packet arrives mid-local-packet.
  -> it is forwarded intact after the local tlast; sentCount=2 at the next strobe.
REQ-023 Overflow: FIFO_DEPTH=8, TX_tready=0, three back-to-back upstream packets.
  -> two packets accepted, third dropped; at the next strobe droppedCount=1; overrun=1 until overrunClear.
REQ-024 Reset mid-packet: assert reset during LOCAL_X, and separately reset mid-RX-packet.
  -> TX_tvalid=0 next cycle; no partial packet appears; the first post-reset forwarded packet starts with a header.
REQ-025 Double strobe and disabled session: two strobes with TX_tready=0 -> overrun=1; a single packet carrying the second values is sent.
  A strobe with enable=0 -> no local packet sent.

Source files
------------

// File: rtl/bpm_link_tx_pkg.sv
// Shared FOFB link constants, FSM encodings and helpers.
// Used by the BPM link transmitter and the link reader.
package bpm_link_tx_pkg;

  localparam int LINK_W = 32;
  localparam int IDX_W = 9;
  localparam int PKT_LEN = 4;
  localparam int CNT_W = 6;
  localparam int FIFO_W = LINK_W + 1;
  localparam logic [15:0] HEADER_MAGIC = 16'hA5BC;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOCAL_H = 3'd1,
    S_LOCAL_X = 3'd2,
    S_LOCAL_Y = 3'd3,
    S_LOCAL_S = 3'd4,
    S_PASS    = 3'd5
  } tx_state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [LINK_W-1:0] x;
    logic [LINK_W-1:0] y;
    logic [LINK_W-1:0] s;
  } local_pkt_t;

  function automatic logic [LINK_W-1:0] mk_header(
    input logic [15:0]      magic,
    input logic [IDX_W-1:0] idx
  );
    return {magic, {(LINK_W-16-IDX_W){1'b0}}, idx};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             inc
  );
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

endpackage

// File: rtl/bpm_link_tx_if.sv
// Streaming link bundle: 32-bit data with valid/last and ready.
// The RX side of the transmitter drives ready high permanently.
interface bpm_link_tx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/link_tx_fifo.sv
// Synchronous first-word-fall-through FIFO for pass-through words.
// Occupancy counter carries one extra bit so full and empty are distinct.
module link_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bpm_link_tx.sv
// BPM FOFB link transmitter: local 4-word packet per session,
// merged with upstream packets forwarded through a FIFO.
module bpm_link_tx #(
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [15:0] HEADER_MAGIC = bpm_link_tx_pkg::HEADER_MAGIC
) (
  input  logic          auroraUserClk,
  input  logic          auroraReset,
  input  logic          auroraFAstrobe,
  input  logic          enable,
  input  logic [8:0]    localIndex,
  input  logic [31:0]   localX,
  input  logic [31:0]   localY,
  input  logic [31:0]   localS,
  bpm_link_tx_if.slave  RX,
  bpm_link_tx_if.master TX,
  output logic [5:0]    sentCount,
  output logic [5:0]    droppedCount,
  output logic          overrun,
  input  logic          overrunClear
);
  import bpm_link_tx_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t        r_state;
  tx_state_t        w_next;
  local_pkt_t       r_lat;
  local_pkt_t       r_snap;
  logic             r_pend;
  logic             r_ovr;
  logic             r_rx_armed;
  logic             r_rx_sof;
  logic             r_rx_keep;
  logic [CNT_W-1:0] r_sess_sent;
  logic [CNT_W-1:0] r_sess_drop;
  logic [CNT_W-1:0] r_sent;
  logic [CNT_W-1:0] r_drop;

  logic              w_hs;
  logic              w_strobe_en;
  logic              w_sent_ev;
  logic              w_free_ok;
  logic              w_rx_drop;
  logic              w_ovr_ev;
  logic              w_fifo_wr;
  logic              w_fifo_rd;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CW-1:0]     w_fifo_cnt;
  logic [FIFO_W-1:0] w_fifo_q;

  assign RX.tready   = 1'b1;
  assign w_hs        = TX.tvalid && TX.tready;
  assign w_strobe_en = auroraFAstrobe && enable;
  assign w_free_ok   = (CW'(FIFO_DEPTH) - w_fifo_cnt) >= CW'(PKT_LEN);

  // Accept/drop is decided once, on the first word of each packet.
  assign w_rx_drop = RX.tvalid && r_rx_armed && r_rx_sof && !w_free_ok;
  assign w_fifo_wr = RX.tvalid && r_rx_armed && !w_fifo_full
                  && (r_rx_sof ? w_free_ok : r_rx_keep);
  assign w_fifo_rd = (r_state == S_PASS) && TX.tready && !w_fifo_empty;

  assign w_sent_ev = w_hs && ((r_state == S_LOCAL_S)
                  || ((r_state == S_PASS) && TX.tlast));
  assign w_ovr_ev  = w_rx_drop || (auroraFAstrobe && r_pend);

  assign sentCount    = r_sent;
  assign droppedCount = r_drop;
  assign overrun      = r_ovr;

  link_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .i_clk   (auroraUserClk),
    .i_rst   (auroraReset),
    .i_wr    (w_fifo_wr),
    .i_wdata ({RX.tlast, RX.tdata}),
    .i_rd    (w_fifo_rd),
    .o_rdata (w_fifo_q),
    .o_count (w_fifo_cnt),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    TX.tvalid = 1'b0;
    TX.tdata  = '0;
    TX.tlast  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // A word being written now is visible on TX next cycle.
        if (r_pend) w_next = S_LOCAL_H;
        else if (!w_fifo_empty || w_fifo_wr) w_next = S_PASS;
      end
      S_LOCAL_H: begin
        TX.tvalid = 1'b1;
        TX.tdata  = mk_header(HEADER_MAGIC, r_snap.idx);
        if (TX.tready) w_next = S_LOCAL_X;
      end
      S_LOCAL_X: begin
        TX.tvalid = 1'b1;
        TX.tdata  = r_snap.x;
        if (TX.tready) w_next = S_LOCAL_Y;
      end
      S_LOCAL_Y: begin
        TX.tvalid = 1'b1;
        TX.tdata  = r_snap.y;
        if (TX.tready) w_next = S_LOCAL_S;
      end
      S_LOCAL_S: begin
        TX.tvalid = 1'b1;
        TX.tdata  = r_snap.s;
        TX.tlast  = 1'b1;
        if (TX.tready) w_next = S_IDLE;
      end
      S_PASS: begin
        TX.tvalid = !w_fifo_empty;
        TX.tdata  = w_fifo_q[LINK_W-1:0];
        TX.tlast  = w_fifo_q[LINK_W];
        if (w_hs && w_fifo_q[LINK_W]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge auroraUserClk) begin
    if (auroraReset) begin
      r_lat       <= '0;
      r_snap      <= '0;
      r_pend      <= 1'b0;
      r_ovr       <= 1'b0;
      r_rx_armed  <= 1'b0;
      r_rx_sof    <= 1'b0;
      r_rx_keep   <= 1'b0;
      r_sess_sent <= '0;
      r_sess_drop <= '0;
      r_sent      <= '0;
      r_drop      <= '0;
    end else begin
      // Snapshot so a later strobe cannot alter a packet in flight.
      if ((r_state == S_IDLE) && r_pend) r_snap <= r_lat;
      if (w_strobe_en) begin
        r_lat  <= {localIndex, localX, localY, localS};
        r_pend <= 1'b1;
      end else if ((r_state == S_LOCAL_S) && w_hs) begin
        r_pend <= 1'b0;
      end
      r_ovr <= w_ovr_ev | (r_ovr & ~overrunClear);

      if (RX.tvalid) begin
        if (!r_rx_armed) begin
          if (RX.tlast) begin
            r_rx_armed <= 1'b1;
            r_rx_sof   <= 1'b1;
          end
        end else begin
          if (r_rx_sof) r_rx_keep <= w_free_ok;
          r_rx_sof <= RX.tlast;
        end
      end

      if (auroraFAstrobe) begin
        r_sent      <= r_sess_sent;
        r_drop      <= r_sess_drop;
        r_sess_sent <= CNT_W'(w_sent_ev);
        r_sess_drop <= CNT_W'(w_rx_drop);
      end else begin
        r_sess_sent <= sat_inc(r_sess_sent, w_sent_ev);
        r_sess_drop <= sat_inc(r_sess_drop, w_rx_drop);
      end
    end
  end

endmodule

// File: tb/tb_bpm_link_tx.sv
// Scoreboard bench for bpm_link_tx: expected TX words queued at stimulus
// time and compared by a negedge monitor; counters checked per scenario.
module tb_bpm_link_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic        en = 1'b0;
  logic        ovclr = 1'b0;
  logic [8:0]  idx = '0;
  logic [31:0] lx = '0;
  logic [31:0] ly = '0;
  logic [31:0] ls = '0;
  logic [5:0]  sent;
  logic [5:0]  dropped;
  logic        ovr;

  int n_checks = 0;
  int n_err = 0;
  int n_words = 0;

  logic [32:0] sb[$];
  logic [32:0] m_exp;
  logic [32:0] prev_word = '0;
  logic        prev_stall = 1'b0;

  bpm_link_tx_if rx_if();
  bpm_link_tx_if tx_if();

  always #5 clk = ~clk;

  bpm_link_tx #(.FIFO_DEPTH(8)) dut (
    .auroraUserClk  (clk),
    .auroraReset    (rst),
    .auroraFAstrobe (strobe),
    .enable         (en),
    .localIndex     (idx),
    .localX         (lx),
    .localY         (ly),
    .localS         (ls),
    .RX             (rx_if),
    .TX             (tx_if),
    .sentCount      (sent),
    .droppedCount   (dropped),
    .overrun        (ovr),
    .overrunClear   (ovclr)
  );

  always @(negedge clk) begin
    if (!rst && tx_if.tvalid && tx_if.tready) begin
      n_checks++;
      n_words++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL tx_unexpected got %h", {tx_if.tlast, tx_if.tdata});
      end else begin
        m_exp = sb.pop_front();
        if ({tx_if.tlast, tx_if.tdata} !== m_exp) begin
          n_err++;
          $display("FAIL tx_word got %h exp %h",
                   {tx_if.tlast, tx_if.tdata}, m_exp);
        end
      end
    end
    if (!rst && prev_stall) begin
      n_checks++;
      if (tx_if.tvalid !== 1'b1 || {tx_if.tlast, tx_if.tdata} !== prev_word) begin
        n_err++;
        $display("FAIL tx_stable got v=%b %h exp v=1 %h",
                 tx_if.tvalid, {tx_if.tlast, tx_if.tdata}, prev_word);
      end
    end
    prev_stall = !rst && tx_if.tvalid && !tx_if.tready;
    prev_word  = {tx_if.tlast, tx_if.tdata};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_local(input logic [8:0] i, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] s);
    sb.push_back({1'b0, 16'hA5BC, 7'b0, i});
    sb.push_back({1'b0, x});
    sb.push_back({1'b0, y});
    sb.push_back({1'b1, s});
  endtask

  task automatic pulse_strobe(input logic e, input logic [8:0] i,
                              input logic [31:0] x, input logic [31:0] y,
                              input logic [31:0] s);
    strobe = 1'b1;
    en = e;
    idx = i;
    lx = x;
    ly = y;
    ls = s;
    step();
    strobe = 1'b0;
    en = 1'b0;
  endtask

  task automatic rx_pkt(input logic [31:0] base, input bit push,
                        input bit clr_first);
    for (int i = 0; i < 4; i++) begin
      rx_if.tvalid = 1'b1;
      rx_if.tdata = base + 32'(i);
      rx_if.tlast = (i == 3);
      ovclr = clr_first && (i == 0);
      if (push) sb.push_back({i == 3, base + 32'(i)});
      step();
    end
    rx_if.tvalid = 1'b0;
    rx_if.tlast = 1'b0;
    ovclr = 1'b0;
  endtask

  task automatic rx_arm();
    rx_if.tvalid = 1'b1;
    rx_if.tdata = 32'hFFFF_FFFF;
    rx_if.tlast = 1'b1;
    step();
    rx_if.tvalid = 1'b0;
    rx_if.tlast = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int t = 0;
    while (sb.size() != 0 && t < budget) begin
      step();
      t++;
    end
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_if.tready = 1'b0;
    rx_if.tvalid = 1'b0;
    rx_if.tdata = '0;
    rx_if.tlast = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (tx_if.tvalid !== 1'b0 || tx_if.tlast !== 1'b0) begin
      n_err++;
      $display("FAIL reset_tx_ctl got v=%b l=%b exp 0 0", tx_if.tvalid, tx_if.tlast);
    end
    n_checks++;
    if (tx_if.tdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_tx_data got %h exp 0", tx_if.tdata);
    end
    n_checks++;
    if (sent !== 6'd0 || dropped !== 6'd0) begin
      n_err++;
      $display("FAIL reset_counts got %0d %0d exp 0 0", sent, dropped);
    end
    n_checks++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_overrun got %b exp 0", ovr);
    end
    step();
    rst = 1'b0;
    rx_arm();
    step();
  endtask

  task automatic test_local();
    int t = 0;
    tx_if.tready = 1'b1;
    push_local(9'h12A, 32'd1, 32'd2, 32'd3);
    pulse_strobe(1'b1, 9'h12A, 32'd1, 32'd2, 32'd3);
    @(negedge clk);
    while (!tx_if.tvalid && t < 10) begin
      @(negedge clk);
      t++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tx_if.tvalid !== 1'b1 || tx_if.tlast !== (i == 3)) begin
        n_err++;
        $display("FAIL local_seq word %0d got v=%b l=%b exp v=1 l=%b",
                 i, tx_if.tvalid, tx_if.tlast, i == 3);
      end
      @(negedge clk);
    end
    n_checks++;
    if (tx_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL local_extra got v=%b exp 0", tx_if.tvalid);
    end
    step();
    pulse_strobe(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (sent !== 6'd1) begin
      n_err++;
      $display("FAIL local_sentCount got %0d exp 1", sent);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int w0 = n_words;
    tx_if.tready = 1'b1;
    push_local(9'h055, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);
    pulse_strobe(1'b1, 9'h055, 32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D);
    @(negedge clk);
    n_checks++;
    if (sent !== 6'd0) begin
      n_err++;
      $display("FAIL bp_open_sentCount got %0d exp 0", sent);
    end
    step();
    for (int i = 0; i < 24; i++) begin
      tx_if.tready = pat[i % 4];
      step();
    end
    tx_if.tready = 1'b1;
    wait_empty(20);
    n_checks++;
    if (n_words - w0 !== 4) begin
      n_err++;
      $display("FAIL bp_word_count got %0d exp 4", n_words - w0);
    end
    pulse_strobe(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (sent !== 6'd1) begin
      n_err++;
      $display("FAIL bp_sentCount got %0d exp 1", sent);
    end
    step();
  endtask

  task automatic test_pass_during_local();
    tx_if.tready = 1'b1;
    push_local(9'h1FF, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC);
    pulse_strobe(1'b1, 9'h1FF, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC);
    step();
    step();
    n_checks++;
    if (tx_if.tvalid !== 1'b1 || tx_if.tdata !== 32'h0000_00AA) begin
      n_err++;
      $display("FAIL pass_mid_local got v=%b %h exp v=1 000000aa",
               tx_if.tvalid, tx_if.tdata);
    end
    rx_pkt(32'h5A5A_0100, 1'b1, 1'b0);
    wait_empty(30);
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL pass_drain got %0d left exp 0", sb.size());
    end
    pulse_strobe(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (sent !== 6'd2) begin
      n_err++;
      $display("FAIL pass_sentCount got %0d exp 2", sent);
    end
    step();
  endtask

  task automatic test_overflow();
    tx_if.tready = 1'b0;
    pulse_strobe(1'b0, '0, '0, '0, '0);
    n_checks++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_pre_overrun got %b exp 0", ovr);
    end
    rx_pkt(32'h0001_0000, 1'b1, 1'b0);
    rx_pkt(32'h0002_0000, 1'b1, 1'b0);
    rx_pkt(32'h0003_0000, 1'b0, 1'b1);
    n_checks++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_clear_vs_event got %b exp 1", ovr);
    end
    step();
    step();
    pulse_strobe(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (dropped !== 6'd1 || sent !== 6'd0) begin
      n_err++;
      $display("FAIL ovf_counts got d=%0d s=%0d exp d=1 s=0", dropped, sent);
    end
    n_checks++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_sticky got %b exp 1", ovr);
    end
    step();
    ovclr = 1'b1;
    step();
    ovclr = 1'b0;
    n_checks++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_cleared got %b exp 0", ovr);
    end
    tx_if.tready = 1'b1;
    wait_empty(40);
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL ovf_drain got %0d left exp 0", sb.size());
    end
    pulse_strobe(1'b0, '0, '0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (sent !== 6'd2 || dropped !== 6'd0) begin
      n_err++;
      $display("FAIL ovf_next_counts got s=%0d d=%0d exp s=2 d=0", sent, dropped);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int w0;
    tx_if.tready = 1'b0;
    pulse_strobe(1'b1, 9'h0AB, 32'h1111, 32'h2222, 32'h3333);
    while (!tx_if.tvalid && t < 10) begin
      step();
      t++;
    end
    sb.push_back({1'b0, 16'hA5BC, 7'b0, 9'h0AB});
    tx_if.tready = 1'b1;
    step();
    tx_if.tready = 1'b0;
    n_checks++;
    if (tx_if.tvalid !== 1'b1 || tx_if.tdata !== 32'h1111) begin
      n_err++;
      $display("FAIL rst_in_local_x got v=%b %h exp v=1 00001111",
               tx_if.tvalid, tx_if.tdata);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_local_valid got %b exp 0", tx_if.tvalid);
    end
    step();
    w0 = n_words;
    tx_if.tready = 1'b1;
    repeat (12) step();
    n_checks++;
    if (n_words != w0 || sb.size() != 0) begin
      n_err++;
      $display("FAIL rst_local_partial got %0d words exp 0", n_words - w0);
    end

    rx_arm();
    tx_if.tready = 1'b0;
    rx_if.tvalid = 1'b1;
    rx_if.tlast = 1'b0;
    rx_if.tdata = 32'hBAD0_0001;
    step();
    rx_if.tdata = 32'hBAD0_0002;
    step();
    rx_if.tdata = 32'hBAD0_0003;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rx_if.tdata = 32'hBAD0_0004;
    rx_if.tlast = 1'b1;
    @(negedge clk);
    n_checks++;
    if (tx_if.tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_rx_valid got %b exp 0", tx_if.tvalid);
    end
    step();
    rx_if.tvalid = 1'b0;
    rx_if.tlast = 1'b0;
    rx_pkt(32'hA5BC_0077, 1'b1, 1'b0);
    tx_if.tready = 1'b1;
    wait_empty(30);
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL rst_rx_forward got %0d left exp 0", sb.size());
    end
  endtask

  task automatic test_double_strobe();
    int w0;
    tx_if.tready = 1'b0;
    rx_pkt(32'h0C0C_0000, 1'b1, 1'b0);
    step();
    pulse_strobe(1'b1, 9'h011, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003);
    step();
    step();
    n_checks++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL dbl_first_overrun got %b exp 0", ovr);
    end
    push_local(9'h022, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003);
    pulse_strobe(1'b1, 9'h022, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003);
    n_checks++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL dbl_overrun got %b exp 1", ovr);
    end
    tx_if.tready = 1'b1;
    wait_empty(30);
    step();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL dbl_drain got %0d left exp 0", sb.size());
    end
    w0 = n_words;
    pulse_strobe(1'b0, 9'h033, 32'h1, 32'h2, 32'h3);
    repeat (15) step();
    n_checks++;
    if (n_words != w0) begin
      n_err++;
      $display("FAIL disabled_session got %0d words exp 0", n_words - w0);
    end
  endtask

  initial begin
    test_reset();
    test_local();
    test_backpressure();
    test_pass_during_local();
    test_overflow();
    test_reset_mid();
    test_double_strobe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
